// File: rtl/neural_soc_led_pio_pkg.sv
// Register offsets for the LED parallel output port.
package neural_soc_led_pio_pkg;

  localparam logic [2:0] LED_PIO_DATA     = 3'd0;
  localparam logic [2:0] LED_PIO_DUTY     = 3'd2;
  localparam logic [2:0] LED_PIO_OUTSET   = 3'd4;
  localparam logic [2:0] LED_PIO_OUTCLEAR = 3'd5;

endpackage

// File: rtl/neural_soc_pwm_gen.sv
// Free-running PWM counter and duty comparator.
// A duty of all-ones means permanently on.
module neural_soc_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_on_o
);

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;

  assign cnt_d    = cnt_q + PWM_BITS'(1);
  assign pwm_on_o = (&duty_i) | (cnt_q < duty_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= {PWM_BITS{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/neural_soc_led_pio.sv
// Avalon-MM LED output port with DATA, OUTSET and OUTCLEAR registers.
// Define NEURAL_SOC_LED_PIO_PWM_EN to add the global PWM dimmer (DUTY register).
module neural_soc_led_pio
  import neural_soc_led_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter int               PWM_BITS    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en_s;
  logic [WIDTH-1:0] wr_bits_s;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [31:0]      rd_mux_s;
  logic [31:0]      readdata_q;
  logic             unused_wd_s;

  assign wr_en_s     = chipselect & ~write_n;
  assign wr_bits_s   = writedata[WIDTH-1:0];
  assign unused_wd_s = ^writedata;

  always_comb begin
    data_d = data_q;
    if (wr_en_s) begin
      case (address)
        LED_PIO_DATA:     data_d = wr_bits_s;
        LED_PIO_OUTSET:   data_d = data_q | wr_bits_s;
        LED_PIO_OUTCLEAR: data_d = data_q & ~wr_bits_s;
        default:          data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

`ifdef NEURAL_SOC_LED_PIO_PWM_EN
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_d;
  logic [WIDTH-1:0]    out_q;
  logic                pwm_on_s;

  always_comb begin
    duty_d = duty_q;
    if (wr_en_s && (address == LED_PIO_DUTY)) begin
      duty_d = writedata[PWM_BITS-1:0];
    end else begin
      duty_d = duty_q;
    end
  end

  neural_soc_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .duty_i   (duty_q),
    .pwm_on_o (pwm_on_s)
  );

  // Gating stage adds one edge of latency between DATA and the pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_q <= {PWM_BITS{1'b1}};
      out_q  <= RESET_VALUE;
    end else begin
      duty_q <= duty_d;
      out_q  <= data_q & {WIDTH{pwm_on_s}};
    end
  end

  assign out_port = out_q;
`else
  assign out_port = data_q;
`endif

  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      LED_PIO_DATA: rd_mux_s = 32'(data_q);
`ifdef NEURAL_SOC_LED_PIO_PWM_EN
      LED_PIO_DUTY: rd_mux_s = 32'(duty_q);
`endif
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // Readback samples pre-edge contents, so a same-edge write returns the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      readdata_q <= 32'd0;
    end else begin
      data_q     <= data_d;
      readdata_q <= rd_mux_s;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_neural_soc_led_pio.sv
// Directed, table-driven bench for neural_soc_led_pio (WIDTH=8, RESET_VALUE=8'hA5, PWM_BITS=4).
module tb_neural_soc_led_pio;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_pass;
  int n_total;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[12];

  neural_soc_led_pio #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5),
    .PWM_BITS    (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    bus(1'b1, 1'b0, a, wd);
    tick();
    bus(1'b0, 1'b1, 3'd0, 32'd0);
  endtask

  task automatic pwm_window(input string name, input int exp_on);
    int on_cnt;
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_port == 8'hFF) on_cnt++;
      else if (out_port != 8'h00) check({name, "_level"}, {24'd0, out_port}, 32'h0);
      tick();
    end
    check({name, "_on_count"}, on_cnt, exp_on);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    //             cs    wn    addr  wdata          exp_rd        exp_data
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'hFFFF_FF3C, 32'h0000_00A5, 8'h3C};
    vecs[1]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0081, 32'h0,        8'hBD};
    vecs[2]  = '{1'b1, 1'b0, 3'd5, 32'h0000_000C, 32'h0,        8'hB1};
    vecs[3]  = '{1'b1, 1'b0, 3'd1, 32'h0000_00FF, 32'h0,        8'hB1};
    vecs[4]  = '{1'b1, 1'b0, 3'd3, 32'h0000_00FF, 32'h0,        8'hB1};
    vecs[5]  = '{1'b1, 1'b0, 3'd6, 32'h0000_00FF, 32'h0,        8'hB1};
    vecs[6]  = '{1'b1, 1'b0, 3'd7, 32'h0000_0000, 32'h0,        8'hB1};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_00B1, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 3'd0, 32'h0000_0055, 32'h0,        8'h55};
    vecs[9]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_0055, 8'h55};
    vecs[10] = '{1'b1, 1'b1, 3'd0, 32'h0000_0000, 32'h0000_0055, 8'h55};
    vecs[11] = '{1'b1, 1'b0, 3'd5, 32'hFFFF_FF00, 32'h0,        8'h55};

    reset_n = 1'b0;
    bus(1'b0, 1'b1, 3'd0, 32'd0);
    #12;
    check("reset_out_port", {24'd0, out_port}, 32'h0000_00A5);
    check("reset_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_reset_read", readdata, 32'h0000_00A5);
    check("post_reset_out", {24'd0, out_port}, 32'h0000_00A5);

    for (int i = 0; i < 12; i++) begin
      bus(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wdata);
      tick();
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      bus(1'b0, 1'b1, 3'd0, 32'd0);
      tick();
      check($sformatf("vec%0d_data", i), readdata, {24'd0, vecs[i].exp_data});
      tick();
      check($sformatf("vec%0d_out", i), {24'd0, out_port}, {24'd0, vecs[i].exp_data});
    end

`ifdef NEURAL_SOC_LED_PIO_PWM_EN
    bus(1'b0, 1'b1, 3'd2, 32'd0);
    tick();
    check("duty_reset_read", readdata, 32'h0000_000F);
    wr(3'd0, 32'h0000_00FF);
    wr(3'd2, 32'hFFFF_FFF4);
    bus(1'b0, 1'b1, 3'd2, 32'd0);
    tick();
    check("duty_read", readdata, 32'h0000_0004);
    tick();
    pwm_window("duty4", 4);
    wr(3'd2, 32'h0000_0000);
    tick(); tick();
    pwm_window("duty0", 0);
    wr(3'd2, 32'h0000_000F);
    tick(); tick();
    pwm_window("dutyF", 16);
`else
    wr(3'd2, 32'h0000_0003);
    bus(1'b0, 1'b1, 3'd2, 32'd0);
    tick();
    check("duty_absent_read", readdata, 32'h0);
    check("duty_absent_out", {24'd0, out_port}, 32'h0000_0055);
`endif

    // Write in flight when reset pulses: it must not land.
    bus(1'b1, 1'b0, 3'd0, 32'h0000_0012);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_out", {24'd0, out_port}, 32'h0000_00A5);
    check("midreset_rd", readdata, 32'h0);
    bus(1'b0, 1'b1, 3'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("midreset_data", readdata, 32'h0000_00A5);
    bus(1'b0, 1'b1, 3'd2, 32'd0);
    tick();
`ifdef NEURAL_SOC_LED_PIO_PWM_EN
    check("midreset_duty", readdata, 32'h0000_000F);
`else
    check("midreset_duty", readdata, 32'h0);
`endif
    check("midreset_out_after", {24'd0, out_port}, 32'h0000_00A5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
